// File: rtl/video_timing_pkg.sv
// PAL raster constants, counter types and window helpers shared by the sync
// generator and the composite encoder so both agree on one set of timings.
package video_timing_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 9;

  localparam int PAL_H_TOTAL      = 1536;
  localparam int PAL_H_SYNC       = 113;
  localparam int PAL_H_ACT_START  = 256;
  localparam int PAL_H_ACT_LEN    = 1248;
  localparam int PAL_V_TOTAL      = 312;
  localparam int PAL_V_SYNC_LINES = 3;
  localparam int PAL_V_ACT_START  = 23;
  localparam int PAL_V_ACT_LEN    = 288;

  // Colourburst gate used by the encoder, in clocks from the line start.
  localparam int PAL_BURST_START  = 139;
  localparam int PAL_BURST_END    = 202;

  typedef logic [H_CNT_W-1:0] hcnt_t;
  typedef logic [V_CNT_W-1:0] vcnt_t;

  typedef enum logic [1:0] {
    LINE_VSYNC,
    LINE_BLANK,
    LINE_ACTIVE
  } line_kind_t;

  function automatic logic h_in_win(input hcnt_t h, input hcnt_t lo, input hcnt_t hi);
    return (h >= lo) && (h <= hi);
  endfunction

  function automatic logic in_burst(input hcnt_t h);
    return h_in_win(h, hcnt_t'(PAL_BURST_START), hcnt_t'(PAL_BURST_END));
  endfunction

endpackage

// File: rtl/pal_sync_gen_if.sv
// Raster output bundle: sync/blanking to the composite encoder, pixel
// coordinates and data enable to the framebuffer side.
interface pal_sync_gen_if;

  logic                       tv_hs_o;
  logic                       tv_vs_o;
  logic                       tv_porch_o;
  logic                       de_o;
  video_timing_pkg::hcnt_t    x_o;
  video_timing_pkg::vcnt_t    y_o;
  logic                       field_o;
  logic                       frame_start_o;

  modport master (
    output tv_hs_o,
    output tv_vs_o,
    output tv_porch_o,
    output de_o,
    output x_o,
    output y_o,
    output field_o,
    output frame_start_o
  );

  modport slave (
    input tv_hs_o,
    input tv_vs_o,
    input tv_porch_o,
    input de_o,
    input x_o,
    input y_o,
    input field_o,
    input frame_start_o
  );

endinterface

// File: rtl/pal_sync_gen_sync_shape.sv
// Combinational map from raster position (h_cnt, v_cnt) to the next values of
// hs/vs/de and the pixel coordinates; the top registers everything.
module sync_shape
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL      = PAL_H_TOTAL,
  parameter int H_SYNC       = PAL_H_SYNC,
  parameter int H_ACT_START  = PAL_H_ACT_START,
  parameter int H_ACT_LEN    = PAL_H_ACT_LEN,
  parameter int V_SYNC_LINES = PAL_V_SYNC_LINES,
  parameter int V_ACT_START  = PAL_V_ACT_START,
  parameter int V_ACT_LEN    = PAL_V_ACT_LEN
) (
  input  hcnt_t h_cnt,
  input  vcnt_t v_cnt,
  output logic  hs_next,
  output logic  vs_next,
  output logic  de_next,
  output logic  frame_start_next,
  output logic  y_load,
  output hcnt_t x_next,
  output vcnt_t y_next
);

  localparam hcnt_t H_SYNC_END = hcnt_t'(H_SYNC - 1);
  localparam hcnt_t SERR_A_LO  = hcnt_t'(H_TOTAL / 2 - H_SYNC);
  localparam hcnt_t SERR_A_HI  = hcnt_t'(H_TOTAL / 2 - 1);
  localparam hcnt_t SERR_B_LO  = hcnt_t'(H_TOTAL - H_SYNC);
  localparam hcnt_t H_END      = hcnt_t'(H_TOTAL - 1);
  localparam hcnt_t H_ACT_LO   = hcnt_t'(H_ACT_START);
  localparam hcnt_t H_ACT_HI   = hcnt_t'(H_ACT_START + H_ACT_LEN - 1);
  localparam vcnt_t V_SYNC_N   = vcnt_t'(V_SYNC_LINES);
  localparam vcnt_t V_ACT_LO   = vcnt_t'(V_ACT_START);
  localparam vcnt_t V_ACT_HI   = vcnt_t'(V_ACT_START + V_ACT_LEN - 1);

  line_kind_t kind;

  always_comb begin
    kind = LINE_BLANK;
    if (v_cnt < V_SYNC_N) begin
      kind = LINE_VSYNC;
    end else if ((v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI)) begin
      kind = LINE_ACTIVE;
    end
  end

  // Vsync lines keep hs low only at the two serrations ending each half line,
  // so every broad pulse ends with an hs falling edge the encoder can count.
  always_comb begin
    hs_next = 1'b1;
    vs_next = 1'b1;
    de_next = 1'b0;
    x_next  = '0;
    if (kind == LINE_VSYNC) begin
      vs_next = 1'b0;
      hs_next = ~(h_in_win(h_cnt, SERR_A_LO, SERR_A_HI) ||
                  h_in_win(h_cnt, SERR_B_LO, H_END));
    end else begin
      hs_next = ~h_in_win(h_cnt, '0, H_SYNC_END);
      if ((kind == LINE_ACTIVE) && h_in_win(h_cnt, H_ACT_LO, H_ACT_HI)) begin
        de_next = 1'b1;
        x_next  = h_cnt - H_ACT_LO;
      end
    end
  end

  assign y_load           = (kind == LINE_ACTIVE) && (h_cnt == '0);
  assign y_next           = v_cnt - V_ACT_LO;
  assign frame_start_next = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/pal_sync_gen.sv
// PAL raster timing generator: line/field counters on clk24 and registered
// sync, blanking and pixel-coordinate outputs, one clock behind the counters.
module pal_sync_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL      = PAL_H_TOTAL,
  parameter int H_SYNC       = PAL_H_SYNC,
  parameter int H_ACT_START  = PAL_H_ACT_START,
  parameter int H_ACT_LEN    = PAL_H_ACT_LEN,
  parameter int V_TOTAL      = PAL_V_TOTAL,
  parameter int V_SYNC_LINES = PAL_V_SYNC_LINES,
  parameter int V_ACT_START  = PAL_V_ACT_START,
  parameter int V_ACT_LEN    = PAL_V_ACT_LEN,
  parameter bit INTERLACE    = 1'b0
) (
  input  logic           clk24,
  input  logic           reset,
  pal_sync_gen_if.master tv
);

  localparam hcnt_t H_LAST     = hcnt_t'(H_TOTAL - 1);
  localparam vcnt_t V_LAST     = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t V_LAST_ODD = vcnt_t'(V_TOTAL);

  hcnt_t h_cnt;
  vcnt_t v_cnt;
  logic  field_q;
  logic  h_last;
  logic  v_last;

  logic  hs_next;
  logic  vs_next;
  logic  de_next;
  logic  frame_start_next;
  logic  y_load;
  hcnt_t x_next;
  vcnt_t y_next;

  logic  hs_q;
  logic  vs_q;
  logic  porch_q;
  logic  de_q;
  hcnt_t x_q;
  vcnt_t y_q;
  logic  field_o_q;
  logic  frame_start_q;

  // In interlaced mode the odd field carries one extra line (313 vs 312).
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (INTERLACE && field_q) ? (v_cnt == V_LAST_ODD) : (v_cnt == V_LAST);

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      field_q <= 1'b0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt   <= '0;
        field_q <= ~field_q;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  sync_shape #(
    .H_TOTAL      (H_TOTAL),
    .H_SYNC       (H_SYNC),
    .H_ACT_START  (H_ACT_START),
    .H_ACT_LEN    (H_ACT_LEN),
    .V_SYNC_LINES (V_SYNC_LINES),
    .V_ACT_START  (V_ACT_START),
    .V_ACT_LEN    (V_ACT_LEN)
  ) u_sync_shape (
    .h_cnt            (h_cnt),
    .v_cnt            (v_cnt),
    .hs_next          (hs_next),
    .vs_next          (vs_next),
    .de_next          (de_next),
    .frame_start_next (frame_start_next),
    .y_load           (y_load),
    .x_next           (x_next),
    .y_next           (y_next)
  );

  // field_q is registered once more so field_o changes together with frame_start_o.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      porch_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      field_o_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= hs_next;
      vs_q          <= vs_next;
      porch_q       <= ~de_next;
      de_q          <= de_next;
      x_q           <= x_next;
      field_o_q     <= field_q;
      frame_start_q <= frame_start_next;
      if (y_load) begin
        y_q <= y_next;
      end
    end
  end

  assign tv.tv_hs_o       = hs_q;
  assign tv.tv_vs_o       = vs_q;
  assign tv.tv_porch_o    = porch_q;
  assign tv.de_o          = de_q;
  assign tv.x_o           = x_q;
  assign tv.y_o           = y_q;
  assign tv.field_o       = field_o_q;
  assign tv.frame_start_o = frame_start_q;

endmodule

// File: doc/pal_sync_gen.md
# pal_sync_gen

PAL raster timing generator running on the 24 MHz system clock. Produces the active-low `tv_hs`/`tv_vs` pair whose XOR forms composite sync (broad pulses with serrations during vertical sync), plus the `tv_porch` blanking flag for the downstream composite encoder. Also drives pixel coordinates and a data-enable strobe for the upstream framebuffer/RGB source.

## Interface
- `H_TOTAL`, 1536: clocks per line (64 µs at 24 MHz).
- `H_SYNC`, 113: horizontal sync width in clocks (4.7 µs).
- `H_ACT_START`, 256: first active clock in the line.
- `H_ACT_LEN`, 1248: active clocks per line (52 µs).
- `V_TOTAL`, 312: lines per field when `INTERLACE`=0.
- `V_SYNC_LINES`, 3: broad-pulse lines at the start of the field.
- `V_ACT_START`, 23: first active line.
- `V_ACT_LEN`, 288: active lines per field.
- `INTERLACE`, 0: when 1, field lengths alternate 312/313 lines (even field 312).
- `clk24` in 1: system clock.
- `reset` in 1: asynchronous reset, active-high.
- `tv_hs_o` out 1: horizontal sync, active low; serrated during vsync lines.
- `tv_vs_o` out 1: vertical sync, active low for `V_SYNC_LINES` lines.
- `tv_porch_o` out 1: blanking; 1 outside the active window.
- `de_o` out 1: active-pixel strobe.
- `x_o` out 11: active pixel index 0..`H_ACT_LEN`-1; 0 when `de_o`=0.
- `y_o` out 9: active line index 0..`V_ACT_LEN`-1; holds the last value outside active lines.
- `field_o` out 1: field parity; toggles at every field start.
- `frame_start_o` out 1: one-clock pulse at h=0 of line 0.

## Operation
- `h_cnt` (11 b) counts 0..`H_TOTAL`-1 and wraps. `v_cnt` (9 b) increments on each `h_cnt` wrap. It wraps after the last line of the field: `V_TOTAL`-1, or `V_TOTAL` when `INTERLACE`=1 and `field_o`=1. `field_o` toggles on each `v_cnt` wrap.
- Normal lines (`v_cnt` ≥ `V_SYNC_LINES`):
  - `tv_vs_o`=1.
  - `tv_hs_o`=0 for h in [0, `H_SYNC`-1], else 1.
- Vsync lines (`v_cnt` < `V_SYNC_LINES`):
  - `tv_vs_o`=0.
  - `tv_hs_o`=0 only for h in [`H_TOTAL`/2-`H_SYNC`, `H_TOTAL`/2-1] and [`H_TOTAL`-`H_SYNC`, `H_TOTAL`-1] (serrations), else 1.
  - Resulting composite sync ~(hs^vs): two broad pulses of 655 clocks per line.
- `de` is high when h is in [`H_ACT_START`, `H_ACT_START`+`H_ACT_LEN`-1] and v is in [`V_ACT_START`, `V_ACT_START`+`V_ACT_LEN`-1].
  - `tv_porch_o` = ~`de`.
  - `x_o` = h-`H_ACT_START`.
  - `y_o` = v-`V_ACT_START`, updated at h=0 of each active line.
- Width rules: all compares are unsigned. `H_TOTAL` must be even. `V_ACT_START`+`V_ACT_LEN` ≤ `V_TOTAL`. Invalid parameter sets are unsupported.

## Timing
- All outputs are registered decodes of the counters, so they lag the counters by exactly 1 clock.
- Reset (async assert, counters and outputs forced immediately):
  - `h_cnt`=0, `v_cnt`=0, `field_o`=0.
  - `tv_hs_o`=1, `tv_vs_o`=1, `tv_porch_o`=1.
  - `de_o`=0, `x_o`=0, `y_o`=0, `frame_start_o`=0.
- First clock after reset deassert: counters leave 0 (h=0 decoded). On the following edge, `frame_start_o`=1, `tv_vs_o`=0 and `tv_hs_o`=1 (vsync line, no serration at h=0).
- Reset asserted mid-field: the raster restarts from line 0, field 0. No partial pulse is stretched.
- Simultaneous h-wrap and v-wrap on one edge: `field_o` toggles and `frame_start_o` pulses on the same output cycle.
- `tv_vs_o` falling edge coincides with h=0. Each vsync line produces exactly two `tv_hs_o` falling edges, which keeps the encoder's line parity intact.

## Structure
- Package `video_timing_pkg` holds the PAL default constants (1536/113/256/1248/312/3/23/288) and the counter widths. The encoder's colourburst window (clocks 139..202) is also defined there, so the two blocks share one source of truth.
- One combinational sub-module is natural: `sync_shape`. It maps (`h_cnt`, `v_cnt`) to the next hs/vs/de values. The top level holds the counters and output registers.

## Test plan
- Release reset, run 2 fields with defaults:
  - `frame_start_o` pulses are 479,232 clocks apart.
  - `field_o` alternates.
  - `tv_hs_o` low for 113 clocks per normal line.
- Vsync line 1: `tv_vs_o`=0 for 4608 clocks. `tv_hs_o` is low at clocks 655..767 and 1423..1535 relative to the line start, high elsewhere.
- Active window:
  - First `de_o`=1 at line 23, h=256 with `x_o`=0, `y_o`=0.
  - Last `de_o`=1 at line 310, h=1503 with `x_o`=1247, `y_o`=287.
  - `tv_porch_o`=~`de_o` throughout.
- `INTERLACE`=1: field 0 lasts 312 lines and field 1 lasts 313 lines (480,768 clocks); the pattern repeats.
- Assert `reset` at line 100, h=700 for 5 clocks:
  - Outputs take reset values asynchronously on assert.
  - After release, the timing restarts at line 0 with `field_o`=0.
- Connect to the encoder: count `tv_hs_o` falling edges between `tv_vs_o` falling edges. The count is 315 (3 vsync lines × 2 + 309 normal lines), which is odd, so line parity toggles across fields.
